trap_ctrl_mc: RTL and testbench

Parametrised multi-channel machine-mode trap controller; successor to the single-external-line trap unit.
- Accepts NUM_IRQ external interrupt lines plus the core timer, each line individually level- or edge-sensitive.
- Arbitrates exceptions and interrupts by fixed priority; captures mepc/mcause/mtval; produces the trap pulse and vector address for fetch.
- Adds a trap-active state that masks interrupts until mret.

---
 rtl/trap_ctrl_mc.sv | 200 ++++++++++++++++++++
 tb/tb_trap_ctrl_mc.sv | 227 ++++++++++++++++++++++
 2 files changed

// File: rtl/trap_ctrl_mc.sv
// rtl/trap_ctrl_mc.sv - multi-channel machine-mode trap controller with per-line level/edge irqs
// Optional debug ports and freeze behaviour enabled by TRAP_CTRL_DBG_EN.
module trap_ctrl_mc #(
  parameter int                 NUM_IRQ        = 4,
  parameter int                 SYNC_STAGES    = 2,
  parameter logic [NUM_IRQ-1:0] IRQ_EDGE_MASK  = '0,
  parameter int                 IRQ_CAUSE_BASE = 16,
  parameter int                 ADDR_WIDTH     = 32,
  parameter int                 DATA_WIDTH     = 32
) (
  input  logic                  cpu_clk,
  input  logic                  cpu_rstn,
  input  logic [NUM_IRQ-1:0]    irq_in,
  input  logic [NUM_IRQ-1:0]    irq_en,
  input  logic [NUM_IRQ-1:0]    irq_clr,
  input  logic                  timer_int,
  input  logic                  mtie,
  input  logic                  mstatus_mie,
  input  logic                  mret,
  input  logic                  pc_misaligned,
  input  logic                  load_x0,
  input  logic                  csr_illegal_access,
  input  logic                  instr_illegal,
  input  logic                  ecall,
  input  logic [ADDR_WIDTH-1:0] pc,
  input  logic [ADDR_WIDTH-1:0] fault_pc,
  input  logic [31:0]           illegal_instr,
  input  logic                  valid_mcsr_wr,
  input  logic                  mcsr_set,
  input  logic                  mcsr_clr,
  input  logic                  mepc_sel,
  input  logic                  mcause_sel,
  input  logic                  mtval_sel,
  input  logic [DATA_WIDTH-1:0] write_data,
  input  logic [1:0]            mtvec_mode,
  input  logic [ADDR_WIDTH-1:0] mtvec_base,
`ifdef TRAP_CTRL_DBG_EN
  input  logic                  dbg_mode,
  input  logic                  dbg_wr,
  input  logic [DATA_WIDTH-1:0] dbg_write_data,
`endif
  output logic [NUM_IRQ-1:0]    irq_pending,
  output logic                  mtip,
  output logic                  exception_met,
  output logic                  valid_interrupt,
  output logic                  trap,
  output logic                  in_trap,
  output logic [ADDR_WIDTH-1:0] vector_addr,
  output logic [ADDR_WIDTH-1:0] mepc,
  output logic [DATA_WIDTH-1:0] mcause,
  output logic [DATA_WIDTH-1:0] mtval
);

  typedef enum logic {S_IDLE, S_TRAP} state_t;

  state_t                  state_q, state_d;
  logic [SYNC_STAGES-1:0]  sync_q [NUM_IRQ];
  logic [NUM_IRQ-1:0]      irq_sync, irq_sync_d, line_valid, take_line;
  logic                    timer_valid, ecall_win;
  logic [DATA_WIDTH-1:0]   int_code, win_cause, mtval_hw;
  logic [ADDR_WIDTH-1:0]   mepc_hw;
  logic                    dbg_mode_i, dbg_wr_i;
  logic [DATA_WIDTH-1:0]   dbg_write_data_i;

`ifdef TRAP_CTRL_DBG_EN
  assign dbg_mode_i       = dbg_mode;
  assign dbg_wr_i         = dbg_wr;
  assign dbg_write_data_i = dbg_write_data;
`else
  assign dbg_mode_i       = 1'b0;
  assign dbg_wr_i         = 1'b0;
  assign dbg_write_data_i = '0;
`endif

  function automatic logic [DATA_WIDTH-1:0] csr_upd(input logic [DATA_WIDTH-1:0] cur,
                                                    input logic [DATA_WIDTH-1:0] wd,
                                                    input logic set, input logic clr);
    if (set)      return cur | wd;
    else if (clr) return cur & ~wd;
    else          return wd;
  endfunction

  always_comb begin
    for (int i = 0; i < NUM_IRQ; i++) irq_sync[i] = sync_q[i][SYNC_STAGES-1];
  end

  // Edge lines need the previous synced level; pending is the mip view.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      for (int i = 0; i < NUM_IRQ; i++) sync_q[i] <= '0;
      irq_sync_d  <= '0;
      irq_pending <= '0;
      mtip        <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_IRQ; i++) begin
        sync_q[i] <= {sync_q[i][SYNC_STAGES-2:0], irq_in[i]};
        if (IRQ_EDGE_MASK[i]) begin
          if (irq_sync[i] && !irq_sync_d[i]) irq_pending[i] <= 1'b1;
          else if (irq_clr[i] || take_line[i]) irq_pending[i] <= 1'b0;
        end else begin
          irq_pending[i] <= irq_sync[i];
        end
      end
      irq_sync_d <= irq_sync;
      mtip       <= timer_int;
    end
  end

  always_comb begin
    exception_met   = pc_misaligned | load_x0 | csr_illegal_access | instr_illegal | ecall;
    line_valid      = irq_pending & irq_en & {NUM_IRQ{mstatus_mie & ~in_trap}};
    timer_valid     = mtip & mtie & mstatus_mie & ~in_trap;
    valid_interrupt = timer_valid | (|line_valid);
    trap            = ~dbg_mode_i & (exception_met | valid_interrupt);
    take_line       = '0;
    int_code        = '0;
    // Descending scan so the lowest-numbered valid line is the one left standing.
    for (int i = NUM_IRQ - 1; i >= 0; i--) begin
      if (line_valid[i]) begin
        int_code     = DATA_WIDTH'(IRQ_CAUSE_BASE + i);
        take_line    = '0;
        take_line[i] = 1'b1;
      end
    end
    if (timer_valid) begin
      int_code  = DATA_WIDTH'(7);
      take_line = '0;
    end
    if (exception_met || !trap) take_line = '0;

    ecall_win = 1'b0;
    mtval_hw  = '0;
    if (pc_misaligned) begin
      win_cause = DATA_WIDTH'(0);
      mtval_hw  = DATA_WIDTH'(fault_pc);
    end else if (load_x0) begin
      win_cause = DATA_WIDTH'(5);
    end else if (csr_illegal_access || instr_illegal) begin
      win_cause = DATA_WIDTH'(2);
      mtval_hw  = DATA_WIDTH'(illegal_instr);
    end else if (ecall) begin
      win_cause = DATA_WIDTH'(11);
      ecall_win = 1'b1;
    end else begin
      win_cause = {1'b1, int_code[DATA_WIDTH-2:0]};
    end
    mepc_hw = ecall_win ? pc - ADDR_WIDTH'(4) : pc;

    if (mtvec_mode == 2'b01 && !exception_met && valid_interrupt)
      vector_addr = mtvec_base + (ADDR_WIDTH'(int_code) << 2);
    else
      vector_addr = mtvec_base;
  end

  always_comb begin
    state_d = state_q;
    if (!dbg_mode_i) begin
      if (trap)                          state_d = S_TRAP;
      else if (mret && state_q == S_TRAP) state_d = S_IDLE;
    end
  end

  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) state_q <= S_IDLE;
    else           state_q <= state_d;
  end

  assign in_trap = (state_q == S_TRAP);

  // Debug write, then software write, then hardware capture, per register.
  always_ff @(posedge cpu_clk or negedge cpu_rstn) begin
    if (!cpu_rstn) begin
      mepc   <= '0;
      mcause <= '1;
      mtval  <= '0;
    end else begin
      if (dbg_wr_i && mepc_sel)
        mepc <= ADDR_WIDTH'(dbg_write_data_i);
      else if (valid_mcsr_wr && mepc_sel)
        mepc <= ADDR_WIDTH'(csr_upd(DATA_WIDTH'(mepc), write_data, mcsr_set, mcsr_clr));
      else if (trap)
        mepc <= mepc_hw;

      if (dbg_wr_i && mcause_sel)
        mcause <= dbg_write_data_i;
      else if (valid_mcsr_wr && mcause_sel)
        mcause <= csr_upd(mcause, write_data, mcsr_set, mcsr_clr);
      else if (trap)
        mcause <= win_cause;

      if (dbg_wr_i && mtval_sel)
        mtval <= dbg_write_data_i;
      else if (valid_mcsr_wr && mtval_sel)
        mtval <= csr_upd(mtval, write_data, mcsr_set, mcsr_clr);
      else if (trap && exception_met)
        mtval <= mtval_hw;
    end
  end

endmodule

// File: tb/tb_trap_ctrl_mc.sv
// tb/tb_trap_ctrl_mc.sv - scoreboard bench for trap_ctrl_mc (line 0 edge, lines 1..3 level)
module tb_trap_ctrl_mc;

  logic        cpu_clk = 1'b0;
  logic        cpu_rstn;
  logic [3:0]  irq_in, irq_en, irq_clr;
  logic        timer_int, mtie, mstatus_mie, mret;
  logic        pc_misaligned, load_x0, csr_illegal_access, instr_illegal, ecall;
  logic [31:0] pc, fault_pc, illegal_instr;
  logic        valid_mcsr_wr, mcsr_set, mcsr_clr, mepc_sel, mcause_sel, mtval_sel;
  logic [31:0] write_data;
  logic [1:0]  mtvec_mode;
  logic [31:0] mtvec_base;
  logic [3:0]  irq_pending;
  logic        mtip, exception_met, valid_interrupt, trap, in_trap;
  logic [31:0] vector_addr, mepc, mcause, mtval;

  typedef struct {
    int          tag;
    logic [31:0] vec, cause, epc, tval;
  } exp_t;

  exp_t exp_q[$];
  int   errors = 0;
  int   checks = 0;

  always #5 cpu_clk = ~cpu_clk;

  trap_ctrl_mc #(
    .NUM_IRQ(4), .SYNC_STAGES(2), .IRQ_EDGE_MASK(4'b0001),
    .IRQ_CAUSE_BASE(16), .ADDR_WIDTH(32), .DATA_WIDTH(32)
  ) dut (
    .cpu_clk(cpu_clk), .cpu_rstn(cpu_rstn), .irq_in(irq_in), .irq_en(irq_en),
    .irq_clr(irq_clr), .timer_int(timer_int), .mtie(mtie), .mstatus_mie(mstatus_mie),
    .mret(mret), .pc_misaligned(pc_misaligned), .load_x0(load_x0),
    .csr_illegal_access(csr_illegal_access), .instr_illegal(instr_illegal), .ecall(ecall),
    .pc(pc), .fault_pc(fault_pc), .illegal_instr(illegal_instr),
    .valid_mcsr_wr(valid_mcsr_wr), .mcsr_set(mcsr_set), .mcsr_clr(mcsr_clr),
    .mepc_sel(mepc_sel), .mcause_sel(mcause_sel), .mtval_sel(mtval_sel),
    .write_data(write_data), .mtvec_mode(mtvec_mode), .mtvec_base(mtvec_base),
    .irq_pending(irq_pending), .mtip(mtip), .exception_met(exception_met),
    .valid_interrupt(valid_interrupt), .trap(trap), .in_trap(in_trap),
    .vector_addr(vector_addr), .mepc(mepc), .mcause(mcause), .mtval(mtval)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge cpu_clk);
      #1;
    end
  endtask

  task automatic expect_trap(input int tag, input logic [31:0] vec, input logic [31:0] cause,
                             input logic [31:0] epc, input logic [31:0] tval);
    exp_t e;
    e.tag = tag; e.vec = vec; e.cause = cause; e.epc = epc; e.tval = tval;
    exp_q.push_back(e);
  endtask

  // Monitor: every trap pulse pops one expectation; CSRs are checked one cycle later.
  initial begin
    exp_t e;
    forever begin
      @(negedge cpu_clk);
      if (cpu_rstn && trap) begin
        if (exp_q.size() == 0) begin
          check("unexpected_trap", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check($sformatf("t%0d_vector", e.tag), vector_addr, e.vec);
          @(negedge cpu_clk);
          check($sformatf("t%0d_mcause", e.tag), mcause, e.cause);
          check($sformatf("t%0d_mepc", e.tag), mepc, e.epc);
          check($sformatf("t%0d_mtval", e.tag), mtval, e.tval);
          check($sformatf("t%0d_in_trap", e.tag), {31'd0, in_trap}, 32'd1);
        end
      end
    end
  end

  task automatic do_mret();
    mret = 1'b1;
    step();
    mret = 1'b0;
  endtask

  initial begin
    cpu_rstn = 1'b0;
    irq_in = '0; irq_en = '0; irq_clr = '0;
    timer_int = 0; mtie = 0; mstatus_mie = 1; mret = 0;
    pc_misaligned = 0; load_x0 = 0; csr_illegal_access = 0; instr_illegal = 0; ecall = 0;
    pc = 32'h400; fault_pc = '0; illegal_instr = '0;
    valid_mcsr_wr = 0; mcsr_set = 0; mcsr_clr = 0; mepc_sel = 0; mcause_sel = 0; mtval_sel = 0;
    write_data = '0; mtvec_mode = 2'b00; mtvec_base = 32'h1000;
    step(3);
    check("rst_pending", {28'd0, irq_pending}, 32'd0);
    check("rst_mtip", {31'd0, mtip}, 32'd0);
    check("rst_in_trap", {31'd0, in_trap}, 32'd0);
    check("rst_mepc", mepc, 32'd0);
    check("rst_mcause", mcause, 32'hFFFF_FFFF);
    check("rst_mtval", mtval, 32'd0);
    cpu_rstn = 1'b1;
    step();

    // Level line 2: 3-cycle latency then trap.
    irq_en = 4'b0100;
    expect_trap(1, 32'h1000, 32'h8000_0012, 32'h400, 32'h0);
    irq_in[2] = 1'b1;
    step(); check("lvl_lat1", {31'd0, irq_pending[2]}, 32'd0);
    step(); check("lvl_lat2", {31'd0, irq_pending[2]}, 32'd0);
    step(); check("lvl_lat3", {31'd0, irq_pending[2]}, 32'd1);
    step(); check("lvl_in_trap", {31'd0, in_trap}, 32'd1);
    irq_in[2] = 1'b0; irq_en = '0;
    do_mret();
    check("lvl_mret_idle", {31'd0, in_trap}, 32'd0);
    step(4);

    // Vectored: timer beats line 1.
    mtvec_mode = 2'b01; mtvec_base = 32'h100;
    mstatus_mie = 0; irq_en = 4'b0010; mtie = 1;
    irq_in[1] = 1'b1; timer_int = 1'b1;
    step(4);
    expect_trap(2, 32'h11C, 32'h8000_0007, 32'h400, 32'h0);
    mstatus_mie = 1;
    step();
    timer_int = 0; mtie = 0; irq_in[1] = 0; irq_en = '0;
    do_mret();
    step(4);
    mtvec_mode = 2'b00; mtvec_base = 32'h1000;

    // Edge line 0: pulse held until taken; second pulse held through in_trap.
    mstatus_mie = 0; irq_en = 4'b0001;
    irq_in[0] = 1'b1; step(); irq_in[0] = 1'b0;
    step(3); check("edge_held_a", {31'd0, irq_pending[0]}, 32'd1);
    step(3); check("edge_held_b", {31'd0, irq_pending[0]}, 32'd1);
    expect_trap(3, 32'h1000, 32'h8000_0010, 32'h400, 32'h0);
    mstatus_mie = 1;
    step(); check("edge_taken_clr", {31'd0, irq_pending[0]}, 32'd0);
    irq_in[0] = 1'b1; step(); irq_in[0] = 1'b0;
    step(3);
    check("edge_second_held", {31'd0, irq_pending[0]}, 32'd1);
    check("edge_still_trap", {31'd0, in_trap}, 32'd1);
    expect_trap(4, 32'h1000, 32'h8000_0010, 32'h400, 32'h0);
    do_mret();
    step();
    check("edge_refire_clr", {31'd0, irq_pending[0]}, 32'd0);
    irq_en = '0;
    do_mret();
    step();

    // ecall beats pending line 3; line fires after mret.
    mstatus_mie = 0; irq_en = 4'b1000; irq_in[3] = 1'b1;
    step(4);
    pc = 32'h208;
    expect_trap(5, 32'h1000, 32'd11, 32'h204, 32'h0);
    mstatus_mie = 1; ecall = 1;
    step(); ecall = 0;
    check("ecall_line_pending", {31'd0, irq_pending[3]}, 32'd1);
    expect_trap(6, 32'h1000, 32'h8000_0013, 32'h208, 32'h0);
    do_mret();
    step();
    irq_in[3] = 0; irq_en = '0;
    do_mret();
    step(4);

    // Misaligned with concurrent software mtval write.
    pc = 32'h300; fault_pc = 32'h302;
    expect_trap(7, 32'h1000, 32'd0, 32'h300, 32'h55);
    pc_misaligned = 1; valid_mcsr_wr = 1; mtval_sel = 1; write_data = 32'h55;
    step();
    pc_misaligned = 0; valid_mcsr_wr = 0; mtval_sel = 0;
    step();
    // mret together with ecall: the trap wins and state stays TRAP.
    pc = 32'h40C;
    expect_trap(8, 32'h1000, 32'd11, 32'h408, 32'h0);
    mret = 1; ecall = 1;
    step();
    mret = 0; ecall = 0;
    check("mret_vs_trap", {31'd0, in_trap}, 32'd1);
    step();
    valid_mcsr_wr = 1; mcause_sel = 1; mcsr_set = 1; write_data = 32'hF0;
    step(); check("sw_set", mcause, 32'hFB);
    mcsr_set = 0; mcsr_clr = 1; write_data = 32'h0F;
    step(); check("sw_clr", mcause, 32'hF0);
    valid_mcsr_wr = 0; mcause_sel = 0; mcsr_clr = 0;
    do_mret();
    step();

    // Edge line: clear coincident with new synced edge, then clear alone.
    irq_in[0] = 1'b1; step(); irq_in[0] = 1'b0;
    step(); irq_clr[0] = 1'b1;
    step(); check("clr_vs_set", {31'd0, irq_pending[0]}, 32'd1);
    step(); check("clr_alone", {31'd0, irq_pending[0]}, 32'd0);
    irq_clr[0] = 1'b0;
    step();

    // Reset while in a trap with a line pending.
    pc = 32'h500;
    expect_trap(9, 32'h1000, 32'd11, 32'h4FC, 32'h0);
    ecall = 1; step(); ecall = 0;
    mstatus_mie = 0; irq_en = 4'b0100; irq_in[2] = 1'b1;
    step(4);
    check("pre_rst_pending", {28'd0, irq_pending}, 32'h4);
    cpu_rstn = 1'b0;
    #1;
    check("rst_mid_in_trap", {31'd0, in_trap}, 32'd0);
    check("rst_mid_mcause", mcause, 32'hFFFF_FFFF);
    check("rst_mid_pending", {28'd0, irq_pending}, 32'd0);
    irq_in = '0; irq_en = '0;
    step(2);
    cpu_rstn = 1'b1;
    step(4);

    check("queue_drained", exp_q.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
